// File: rtl/apb_arbiter.sv
// Two-master to one-slave APB arbiter with round-robin grant and access timeout.
// Each grant is replayed to the slave as a fresh SETUP/ACCESS pair.
module apb_arbiter #(
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic              pclk_i,
  input  logic              preset_i,

  input  logic              m0_psel_i,
  input  logic              m0_penable_i,
  input  logic              m0_pwrite_i,
  input  logic [ADDR_W-1:0] m0_paddr_i,
  input  logic [DATA_W-1:0] m0_pwdata_i,
  output logic [DATA_W-1:0] m0_prdata_o,
  output logic              m0_pready_o,
  output logic              m0_pslverr_o,

  input  logic              m1_psel_i,
  input  logic              m1_penable_i,
  input  logic              m1_pwrite_i,
  input  logic [ADDR_W-1:0] m1_paddr_i,
  input  logic [DATA_W-1:0] m1_pwdata_i,
  output logic [DATA_W-1:0] m1_prdata_o,
  output logic              m1_pready_o,
  output logic              m1_pslverr_o,

  output logic              s_psel_o,
  output logic              s_penable_o,
  output logic              s_pwrite_o,
  output logic [ADDR_W-1:0] s_paddr_o,
  output logic [DATA_W-1:0] s_pwdata_o,
  input  logic [DATA_W-1:0] s_prdata_i,
  input  logic              s_pready_i,
  input  logic              s_pslverr_i,

  output logic [1:0]        gnt_o,
  output logic              busy_o
);

  localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  localparam logic [1:0] IDLE   = 2'b00;
  localparam logic [1:0] SETUP  = 2'b01;
  localparam logic [1:0] ACCESS = 2'b10;

  logic [1:0]    state;
  logic [1:0]    gnt;
  logic          last_gnt;
  logic [CW-1:0] cnt;

  logic          any_req;
  logic          pick1;
  logic          in_access;
  logic          timeout;
  logic          finish;
  logic          unused_penable;

  // Masters' own penable carries no information for the slave phase.
  assign unused_penable = m0_penable_i ^ m1_penable_i;

  assign any_req = m0_psel_i | m1_psel_i;

  // m1 wins when alone, or on a tie when m0 was served last.
  assign pick1 = m1_psel_i & (~m0_psel_i | ~last_gnt);

  assign in_access = (state == ACCESS);
  assign timeout   = in_access & ~s_pready_i & (cnt == CNT_LAST);
  assign finish    = in_access & (s_pready_i | (cnt == CNT_LAST));

  always_ff @(posedge pclk_i or posedge preset_i) begin
    if (preset_i) begin
      state    <= IDLE;
      gnt      <= 2'b00;
      last_gnt <= 1'b1;
      cnt      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            state    <= SETUP;
            gnt      <= pick1 ? 2'b10 : 2'b01;
            last_gnt <= pick1;
            cnt      <= '0;
          end
        end
        SETUP: begin
          state <= ACCESS;
          cnt   <= '0;
        end
        ACCESS: begin
          if (finish) begin
            state <= IDLE;
            gnt   <= 2'b00;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          gnt   <= 2'b00;
        end
      endcase
    end
  end

  assign busy_o      = (state == SETUP) | in_access;
  assign gnt_o       = gnt;
  assign s_psel_o    = busy_o;
  assign s_penable_o = in_access;

  always_comb begin
    s_pwrite_o = 1'b0;
    s_paddr_o  = '0;
    s_pwdata_o = '0;
    if (busy_o) begin
      if (gnt[1]) begin
        s_pwrite_o = m1_pwrite_i;
        s_paddr_o  = m1_paddr_i;
        s_pwdata_o = m1_pwdata_i;
      end else if (gnt[0]) begin
        s_pwrite_o = m0_pwrite_i;
        s_paddr_o  = m0_paddr_i;
        s_pwdata_o = m0_pwdata_i;
      end
    end
  end

  // Response goes only to the granted master; timeout forces an error.
  always_comb begin
    m0_pready_o  = 1'b0;
    m0_pslverr_o = 1'b0;
    m0_prdata_o  = '0;
    m1_pready_o  = 1'b0;
    m1_pslverr_o = 1'b0;
    m1_prdata_o  = '0;
    if (in_access && gnt[0]) begin
      m0_pready_o  = s_pready_i | timeout;
      m0_pslverr_o = s_pslverr_i | timeout;
      m0_prdata_o  = timeout ? '0 : s_prdata_i;
    end
    if (in_access && gnt[1]) begin
      m1_pready_o  = s_pready_i | timeout;
      m1_pslverr_o = s_pslverr_i | timeout;
      m1_prdata_o  = timeout ? '0 : s_prdata_i;
    end
  end

endmodule

// File: tb/tb_apb_arbiter.sv
// Self-checking bench for apb_arbiter: directed scenarios then random traffic
// against a transaction-level round-robin/timeout model.
module tb_apb_arbiter;

  localparam int ADDR_W  = 8;
  localparam int DATA_W  = 32;
  localparam int TIMEOUT = 16;

  logic              clk;
  logic              rst;
  logic              m0_psel, m0_penable, m0_pwrite;
  logic [ADDR_W-1:0] m0_paddr;
  logic [DATA_W-1:0] m0_pwdata, m0_prdata;
  logic              m0_pready, m0_pslverr;
  logic              m1_psel, m1_penable, m1_pwrite;
  logic [ADDR_W-1:0] m1_paddr;
  logic [DATA_W-1:0] m1_pwdata, m1_prdata;
  logic              m1_pready, m1_pslverr;
  logic              s_psel, s_penable, s_pwrite;
  logic [ADDR_W-1:0] s_paddr;
  logic [DATA_W-1:0] s_pwdata, s_prdata;
  logic              s_pready, s_pslverr;
  logic [1:0]        gnt;
  logic              busy;

  apb_arbiter #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .pclk_i      (clk),
    .preset_i    (rst),
    .m0_psel_i   (m0_psel),
    .m0_penable_i(m0_penable),
    .m0_pwrite_i (m0_pwrite),
    .m0_paddr_i  (m0_paddr),
    .m0_pwdata_i (m0_pwdata),
    .m0_prdata_o (m0_prdata),
    .m0_pready_o (m0_pready),
    .m0_pslverr_o(m0_pslverr),
    .m1_psel_i   (m1_psel),
    .m1_penable_i(m1_penable),
    .m1_pwrite_i (m1_pwrite),
    .m1_paddr_i  (m1_paddr),
    .m1_pwdata_i (m1_pwdata),
    .m1_prdata_o (m1_prdata),
    .m1_pready_o (m1_pready),
    .m1_pslverr_o(m1_pslverr),
    .s_psel_o    (s_psel),
    .s_penable_o (s_penable),
    .s_pwrite_o  (s_pwrite),
    .s_paddr_o   (s_paddr),
    .s_pwdata_o  (s_pwdata),
    .s_prdata_i  (s_prdata),
    .s_pready_i  (s_pready),
    .s_pslverr_i (s_pslverr),
    .gnt_o       (gnt),
    .busy_o      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Per-master request parameters and the slave behaviour for its transfer.
  logic [ADDR_W-1:0] a   [2];
  logic [DATA_W-1:0] wd  [2];
  logic              wrv [2];
  int                nw  [2];
  logic [DATA_W-1:0] rd  [2];
  logic              er  [2];
  int                last_w = 1;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_psel"}, s_psel, 0);
    chk({tag, "_pen"}, s_penable, 0);
    chk({tag, "_pwr"}, s_pwrite, 0);
    chk({tag, "_paddr"}, s_paddr, 0);
    chk({tag, "_pwdata"}, s_pwdata, 0);
    chk({tag, "_gnt"}, gnt, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_rdy"}, {m1_pready, m0_pready}, 0);
    chk({tag, "_err"}, {m1_pslverr, m0_pslverr}, 0);
    chk({tag, "_rd0"}, m0_prdata, 0);
    chk({tag, "_rd1"}, m1_prdata, 0);
  endtask

  task automatic drive_m();
    m0_paddr  = a[0];
    m0_pwdata = wd[0];
    m0_pwrite = wrv[0];
    m1_paddr  = a[1];
    m1_pwdata = wd[1];
    m1_pwrite = wrv[1];
  endtask

  // One granted transfer to master w, starting from an IDLE cycle.
  task automatic serve(input int w);
    logic [1:0] g;
    bit done;
    bit to;
    logic [DATA_W-1:0] exp_rd;
    g = (w == 1) ? 2'b10 : 2'b01;
    tick();
    s_pready  = 1'b0;
    s_pslverr = 1'b0;
    s_prdata  = $urandom;
    #1;
    chk("setup_gnt", gnt, g);
    chk("setup_busy", busy, 1);
    chk("setup_psel", s_psel, 1);
    chk("setup_pen", s_penable, 0);
    chk("setup_addr", s_paddr, a[w]);
    chk("setup_write", s_pwrite, wrv[w]);
    chk("setup_wdata", s_pwdata, wd[w]);
    chk("setup_rdy", {m1_pready, m0_pready}, 0);
    for (int k = 0; k < TIMEOUT; k++) begin
      tick();
      done      = (k == nw[w]);
      to        = !done && (k == TIMEOUT - 1);
      s_pready  = done;
      s_pslverr = done & er[w];
      s_prdata  = done ? rd[w] : $urandom;
      exp_rd    = to ? '0 : s_prdata;
      #1;
      chk("acc_psel", s_psel, 1);
      chk("acc_pen", s_penable, 1);
      chk("acc_addr", s_paddr, a[w]);
      chk("acc_gnt", gnt, g);
      chk("acc_rdy_own", (w == 1) ? m1_pready : m0_pready, done | to);
      chk("acc_err_own", (w == 1) ? m1_pslverr : m0_pslverr,
          (done & er[w]) | to);
      chk("acc_rd_own", (w == 1) ? m1_prdata : m0_prdata, exp_rd);
      chk("acc_rdy_oth", (w == 1) ? m0_pready : m1_pready, 0);
      chk("acc_err_oth", (w == 1) ? m0_pslverr : m1_pslverr, 0);
      chk("acc_rd_oth", (w == 1) ? m0_prdata : m1_prdata, 0);
      if (done || to) break;
    end
    if (w == 1) m1_psel = 1'b0;
    else m0_psel = 1'b0;
    tick();
    s_pready  = 1'b0;
    s_pslverr = 1'b0;
    #1;
    chk("idle_psel", s_psel, 0);
    chk("idle_busy", busy, 0);
    chk("idle_gnt", gnt, 0);
    chk("idle_rdy", {m1_pready, m0_pready}, 0);
  endtask

  // Model: a lone requester wins; a tie goes to the master not served last.
  task automatic run(input bit r0, input bit r1);
    bit req [2];
    int w;
    req[0] = r0;
    req[1] = r1;
    drive_m();
    m0_psel = r0;
    m1_psel = r1;
    while (req[0] || req[1]) begin
      if (req[0] && req[1]) w = 1 - last_w;
      else w = req[1] ? 1 : 0;
      serve(w);
      last_w = w;
      req[w] = 0;
    end
  endtask

  task automatic set_m(input int m, input logic [ADDR_W-1:0] ad,
                       input logic [DATA_W-1:0] wdat, input logic w,
                       input int n, input logic [DATA_W-1:0] r,
                       input logic e);
    a[m]   = ad;
    wd[m]  = wdat;
    wrv[m] = w;
    nw[m]  = n;
    rd[m]  = r;
    er[m]  = e;
  endtask

  initial begin
    rst = 1'b1;
    m0_psel = 0; m0_penable = 0; m0_pwrite = 0; m0_paddr = '0; m0_pwdata = '0;
    m1_psel = 0; m1_penable = 0; m1_pwrite = 0; m1_paddr = '0; m1_pwdata = '0;
    s_prdata = '0; s_pready = 0; s_pslverr = 0;
    #3;
    chk_quiet("reset");
    m0_psel = 1'b1;
    m1_psel = 1'b1;
    s_pready = 1'b1;
    repeat (3) tick();
    #1;
    chk_quiet("reset_req");
    s_pready = 1'b0;
    rst = 1'b0;

    // Contention after reset: m0, then m1; the next tie goes to m0 again.
    set_m(0, 8'h30, 32'h0000_0A0A, 1, 0, 32'h1111_0000, 0);
    set_m(1, 8'h31, 32'h0000_0B0B, 0, 1, 32'h2222_0000, 0);
    run(1, 1);
    run(1, 1);

    set_m(0, 8'h10, 32'hDEAD_BEEF, 1, 0, 32'h0, 0);
    run(1, 0);

    set_m(1, 8'h20, 32'h0, 0, 3, 32'h1234_5678, 0);
    run(0, 1);

    set_m(0, 8'h44, 32'h5555_AAAA, 0, TIMEOUT + 4, 32'hFFFF_FFFF, 0);
    run(1, 0);
    set_m(1, 8'h45, 32'h6666_BBBB, 1, TIMEOUT + 1, 32'h0BAD_F00D, 0);
    run(0, 1);

    set_m(0, 8'h50, 32'hCAFE_F00D, 1, 1, 32'h0, 1);
    run(1, 0);

    for (int it = 0; it < 60; it++) begin
      for (int m = 0; m < 2; m++) begin
        set_m(m, ADDR_W'($urandom), $urandom, 1'($urandom_range(0, 1)),
              ($urandom_range(0, 7) == 0) ? TIMEOUT + 2 : $urandom_range(0, 5),
              $urandom, ($urandom_range(0, 3) == 0));
      end
      m0_penable = 1'($urandom);
      m1_penable = 1'($urandom);
      case ($urandom_range(1, 3))
        1: run(1, 0);
        2: run(0, 1);
        default: run(1, 1);
      endcase
    end

    // Reset in the middle of a waited transfer, then a fresh tie.
    set_m(0, 8'h77, 32'h7777_7777, 1, TIMEOUT + 4, 32'h0, 0);
    drive_m();
    m0_psel = 1'b1;
    repeat (3) tick();
    s_pready = 1'b1;
    s_prdata = 32'hA5A5_A5A5;
    rst = 1'b1;
    #1;
    chk_quiet("rst_mid");
    s_pready = 1'b0;
    tick();
    chk_quiet("rst_hold");
    rst = 1'b0;
    last_w = 1;
    set_m(0, 8'h78, 32'h0808_0808, 0, 0, 32'h0C0C_0C0C, 0);
    set_m(1, 8'h79, 32'h0909_0909, 1, 2, 32'h0D0D_0D0D, 0);
    run(1, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/apb_arbiter.md
# apb_arbiter

Two-master, one-slave APB arbiter placed between the Sampler (master 0), the Computer (master 1) and the shared Memory slave. It replaces OR-combining of the master buses with an explicit grant. Each granted request is replayed to the slave as a clean SETUP/ACCESS transfer, and the response is routed back only to the granted master. Round-robin arbitration gives fairness, and an access timeout guarantees that a hung slave cannot lock out either master.

## Interface
Parameters:
- ADDR_W, 8, APB address width
- DATA_W, 32, APB data width
- TIMEOUT, 16, maximum ACCESS cycles without `s_pready_i` before forced error completion (≥2)

Ports:
- pclk_i  in  1  clock, all logic on rising edge
- preset_i  in  1  asynchronous, active-high reset
- m0_psel_i, m0_penable_i, m0_pwrite_i  in  1 each  master 0 APB controls
- m0_paddr_i  in  ADDR_W  master 0 address
- m0_pwdata_i  in  DATA_W  master 0 write data
- m0_prdata_o  out  DATA_W  master 0 read data
- m0_pready_o, m0_pslverr_o  out  1 each  master 0 response
- m1_* — same set as m0_*, for master 1
- s_psel_o, s_penable_o, s_pwrite_o  out  1 each  slave APB controls
- s_paddr_o  out  ADDR_W  slave address
- s_pwdata_o  out  DATA_W  slave write data
- s_prdata_i  in  DATA_W  slave read data
- s_pready_i, s_pslverr_i  in  1 each  slave response
- gnt_o  out  2  one-hot current grant (bit0 = m0, bit1 = m1), 00 when idle
- busy_o  out  1  high in SETUP or ACCESS

## Operation
- FSM states: IDLE, SETUP, ACCESS.
- IDLE: a request is `mX_psel_i` = 1.
  - With one requester, grant it.
  - With both requesting, grant the master not granted last (`last_gnt` register; reset value 1, so m0 wins the first tie).
  - On a grant, register the grant, update `last_gnt` and go to SETUP. With no request, stay in IDLE.
- SETUP: `s_psel_o` = 1, `s_penable_o` = 0. Always one cycle, then ACCESS.
- ACCESS: `s_psel_o` = 1, `s_penable_o` = 1.
  - On `s_pready_i` = 1, complete and return to IDLE.
  - Otherwise increment the wait counter.
- Slave address/write/wdata: combinational mux from the granted master's inputs in SETUP/ACCESS; forced to 0 in IDLE.
- Granted master response: in ACCESS, `mX_pready_o` = `s_pready_i`, `mX_prdata_o` = `s_prdata_i`, `mX_pslverr_o` = `s_pslverr_i` (combinational pass-through).
- Non-granted master: `pready_o`, `pslverr_o` and `prdata_o` are held at 0. It stalls in its own access phase; APB masters hold their signals stable until `pready`.
- Timeout: the wait counter is clog2(TIMEOUT) bits, cleared on SETUP entry. If it reaches TIMEOUT−1 in ACCESS with `s_pready_i` still 0:
  - the granted master gets `pready_o` = 1, `pslverr_o` = 1, `prdata_o` = 0 that cycle;
  - the FSM returns to IDLE and the slave transfer is abandoned.
- Master drops `psel` mid-transfer (protocol violation): the slave transfer completes normally, and the response is still presented on that master's outputs.
- Each master's `penable_i` is ignored. The arbiter generates slave `penable` itself.

## Timing
- Reset (async, immediate): state IDLE, `last_gnt` = 1, counter 0, and every output 0 (including `gnt_o` = 00 and `busy_o` = 0). Reset mid-transfer abandons the transfer with no response to either master.
- Latency for an uncontended zero-wait request that appears in cycle N (IDLE):
  - N+1: SETUP.
  - N+2: ACCESS, with `mX_pready_o` high in the same cycle.
- Minimum slave-bus period: 3 cycles per transfer, since IDLE is revisited between transfers.
- A request arriving in the completion cycle is sampled in the next IDLE cycle.
- `gnt_o` and `busy_o` are registered state decodes, valid from SETUP through the completion cycle of ACCESS.
- Simultaneous requests: exactly one grant, never both. The loser is served in the next arbitration if it is still requesting.

## Test plan
- **Single write, m0**: m0 writes addr 0x10, data 0xDEADBEEF, slave ready immediately.
  - Expect SETUP then ACCESS on the slave bus with `s_paddr_o` = 0x10 and `s_pwdata_o` = 0xDEADBEEF.
  - Expect `m0_pready_o` = 1 at N+2; `m1` outputs stay 0.
- **Read with waits, m1**: m1 reads addr 0x20; slave inserts 3 wait cycles then returns 0x12345678.
  - Expect `m1_pready_o` = 1 only in the 4th ACCESS cycle, with `m1_prdata_o` = 0x12345678.
- **Contention**: after reset, m0 and m1 request in the same cycle.
  - Expect m0 granted first (`gnt_o` = 01), then m1 (`gnt_o` = 10).
  - A repeated tie afterwards grants m0 again, so grants alternate.
- **Timeout**: slave holds `s_pready_i` = 0 with TIMEOUT = 16.
  - After 16 ACCESS cycles expect `pready` = 1, `pslverr` = 1, `prdata` = 0 to the granted master.
  - Expect `s_psel_o` = 0 the next cycle.
- **Slave error**: `s_pslverr_i` = 1 together with `s_pready_i` on an m0 write.
  - Expect `m0_pslverr_o` = 1 for exactly that cycle.
- **Reset mid-ACCESS**: assert `preset_i` during a waited transfer.
  - Expect all outputs 0 immediately.
  - After release, expect a tie to be granted to m0.
